// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: display fetch has priority on the single RAM port,
// pixel writes are queued in a FIFO and retired in cycles with no display fetch.
module vram_arbiter #(
    parameter int SCALE_SHIFT = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 17
) (
    input  logic                          vga_clk,
    input  logic                          rst_n,
    input  logic [9:0]                    pic_x,
    input  logic [9:0]                    pic_y,
    output logic [11:0]                   pic_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [9:0]                    wr_x,
    input  logic [9:0]                    wr_y,
    input  logic [11:0]                   wr_data,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [11:0]                   ram_wdata,
    input  logic [11:0]                   ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt
);

    localparam int FB_W  = 640 >> SCALE_SHIFT;
    localparam int FB_H  = 480 >> SCALE_SHIFT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [11:0]       fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [15:0]       drop_cnt_r;
    logic              rd_pend_r;

    logic              rd_req_s;
    logic              in_range_s;
    logic              full_s;
    logic              xfer_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] disp_addr_s;
    logic [ADDR_W-1:0] push_addr_s;

    assign rd_req_s    = rst_n && (pic_x != 10'h3ff) && (pic_y != 10'h3ff);
    assign in_range_s  = (wr_x < 10'(FB_W)) && (wr_y < 10'(FB_H));
    assign full_s      = (level_r == LVL_W'(FIFO_DEPTH));
    // Ready is not widened by a same-cycle pop: a full FIFO never falls through.
    assign wr_ready    = rst_n && !full_s;
    assign xfer_s      = wr_valid && wr_ready;
    assign push_s      = xfer_s && in_range_s;
    assign pop_s       = rst_n && !rd_req_s && (level_r != LVL_W'(0));
    assign disp_addr_s = ADDR_W'(pic_y >> SCALE_SHIFT) * FB_W_A + ADDR_W'(pic_x >> SCALE_SHIFT);
    assign push_addr_s = ADDR_W'(wr_y) * FB_W_A + ADDR_W'(wr_x);

    assign pic_data   = rd_pend_r ? ram_rdata : 12'h000;
    assign fifo_level = level_r;
    assign drop_cnt   = drop_cnt_r;

    // RAM port mux: display read first, otherwise retire the FIFO head.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = 12'h000;
        if (rd_req_s) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr_s;
        end else if (pop_s) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = fifo_addr_r[rd_ptr_r];
            ram_wdata = fifo_data_r[rd_ptr_r];
        end else begin
            ram_en = 1'b0;
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge vga_clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= push_addr_s;
            fifo_data_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, level, drop counter and read-pending flag.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            drop_cnt_r <= 16'h0000;
            rd_pend_r  <= 1'b0;
        end else begin
            rd_pend_r <= rd_req_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            if (xfer_s && !in_range_s && (drop_cnt_r != 16'hffff)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: display fetch, write queueing, back-pressure,
// out-of-range drops and reset mid-drain, with hand-computed expectations.
module tb_vram_arbiter;

    logic        vga_clk;
    logic        rst_n;
    logic [9:0]  pic_x;
    logic [9:0]  pic_y;
    logic [11:0] pic_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic [11:0] wr_data;
    logic        ram_en;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;
    logic [4:0]  fifo_level;
    logic [15:0] drop_cnt;

    int vec_cnt;
    int err_cnt;

    vram_arbiter #(.SCALE_SHIFT(1), .FIFO_DEPTH(16), .ADDR_W(17)) dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .pic_x      (pic_x),
        .pic_y      (pic_y),
        .pic_data   (pic_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        pic_x     = 10'd5;
        pic_y     = 10'd7;
        wr_valid  = 1'b0;
        wr_x      = 10'd0;
        wr_y      = 10'd0;
        wr_data   = 12'h000;
        ram_rdata = 12'h321;
        #5;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_pic_data", 32'(pic_data), 32'h000);
        @(negedge vga_clk);
        rst_n = 1'b1;

        // 1: display fetch address and one-cycle read latency
        step();
        pic_x = 10'd5; pic_y = 10'd7; ram_rdata = 12'h123;
        #5;
        chk("rd_en", 32'(ram_en), 32'd1);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("rd_addr", 32'(ram_addr), 32'd962);
        step();
        pic_x = 10'h3ff; pic_y = 10'h3ff; ram_rdata = 12'h5a5;
        #5;
        chk("rd_data", 32'(pic_data), 32'h5a5);
        chk("idle_en", 32'(ram_en), 32'd0);
        // 2: no pixel -> black
        step();
        ram_rdata = 12'hfff;
        #5;
        chk("blank_data", 32'(pic_data), 32'h000);

        // 3: single write in blanking
        step();
        wr_valid = 1'b1; wr_x = 10'd10; wr_y = 10'd2; wr_data = 12'habc;
        #5;
        chk("w1_ready", 32'(wr_ready), 32'd1);
        chk("w1_no_same_cycle", 32'(ram_en), 32'd0);
        step();
        wr_valid = 1'b0;
        #5;
        chk("w1_we", 32'(ram_we), 32'd1);
        chk("w1_addr", 32'(ram_addr), 32'd650);
        chk("w1_wdata", 32'(ram_wdata), 32'habc);
        chk("w1_level_mid", 32'(fifo_level), 32'd1);
        step();
        #5;
        chk("w1_level_end", 32'(fifo_level), 32'd0);
        chk("w1_idle", 32'(ram_en), 32'd0);

        // 4: fill during an active line, then drain in order
        pic_x = 10'd0; pic_y = 10'd0;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1; wr_x = 10'(i); wr_y = 10'd1; wr_data = 12'h100 + 12'(i);
            #5;
            chk($sformatf("fill_ready_%0d", i), 32'(wr_ready), (i < 16) ? 32'd1 : 32'd0);
            chk($sformatf("fill_no_we_%0d", i), 32'(ram_we), 32'd0);
            step();
        end
        #5;
        chk("fill_level", 32'(fifo_level), 32'd16);
        pic_x = 10'h3ff; pic_y = 10'h3ff;
        for (int i = 0; i < 16; i++) begin
            wr_valid = (i == 0); wr_x = 10'd50; wr_y = 10'd3; wr_data = 12'h777;
            #5;
            if (i == 0) chk("full_pop_ready", 32'(wr_ready), 32'd0);
            chk($sformatf("drain_we_%0d", i), 32'(ram_we), 32'd1);
            chk($sformatf("drain_addr_%0d", i), 32'(ram_addr), 32'd320 + 32'(i));
            chk($sformatf("drain_data_%0d", i), 32'(ram_wdata), 32'h100 + 32'(i));
            step();
        end
        wr_valid = 1'b0;
        #5;
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_idle", 32'(ram_en), 32'd0);

        // 5: out-of-range writes are dropped
        step();
        wr_valid = 1'b1; wr_x = 10'd320; wr_y = 10'd0; wr_data = 12'h0f0;
        #5;
        chk("drop_ready", 32'(wr_ready), 32'd1);
        step();
        wr_x = 10'd0; wr_y = 10'd240;
        #5;
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
        chk("drop_no_we", 32'(ram_en), 32'd0);
        step();
        wr_valid = 1'b0;
        #5;
        chk("drop_cnt2", 32'(drop_cnt), 32'd2);
        chk("drop_level", 32'(fifo_level), 32'd0);

        // 6: queue 5, drain with a concurrent push, reset mid-drain
        step();
        pic_x = 10'd8; pic_y = 10'd8;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_x = 10'd20 + 10'(i); wr_y = 10'd4; wr_data = 12'h200 + 12'(i);
            step();
        end
        wr_valid = 1'b0; pic_x = 10'h3ff; pic_y = 10'h3ff;
        #5;
        chk("q5_level", 32'(fifo_level), 32'd5);
        chk("q5_head_addr", 32'(ram_addr), 32'd1300);
        step();
        wr_valid = 1'b1; wr_x = 10'd1; wr_y = 10'd0; wr_data = 12'h999;
        #5;
        chk("pp_we", 32'(ram_we), 32'd1);
        chk("pp_addr", 32'(ram_addr), 32'd1301);
        step();
        wr_valid = 1'b0;
        #5;
        chk("pp_level", 32'(fifo_level), 32'd4);
        rst_n = 1'b0;
        #5;
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_en", 32'(ram_en), 32'd0);
        @(negedge vga_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            #5;
            chk($sformatf("post_rst_no_we_%0d", i), 32'(ram_we), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
